kbd_ascii_queue: RTL and testbench

Parametrised PS/2 keystroke-to-ASCII front end. Sits between `KeyboardDecoder` (which supplies `key_valid`, `last_change`, make/break state and shift state) and any character consumer such as the seven-segment display, a text buffer or a UART. It translates make codes to ASCII, tracks Caps Lock, and optionally generates typematic auto-repeat. Characters are buffered in a DEPTH-entry FIFO with a valid/ready output handshake, and the last two accepted characters are exposed for display.

---
 rtl/kbd_ascii_queue.sv | 195 +++++++++++++++++++
 tb/tb_kbd_ascii_queue.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_ascii_queue.sv
// PS/2 make-code to ASCII translator with Caps Lock tracking and an output FIFO.
// Define KBD_AUTOREPEAT_EN to build in the typematic auto-repeat FSM and timer.
module kbd_ascii_queue #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           key_valid,
  input  logic [8:0]                     key_code,
  input  logic                           key_make,
  input  logic                           shift_down,
  input  logic                           out_ready,
  input  logic                           ovf_clr,
  output logic                           out_valid,
  output logic [7:0]                     out_ascii,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           overflow,
  output logic                           caps_lock,
  output logic [7:0]                     last_ascii,
  output logic [7:0]                     prev_ascii
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  // Returns {translatable, ascii}; extended codes and unknown codes are not translatable.
  function automatic logic [8:0] xlate(input logic [8:0] code, input logic shift,
                                       input logic caps);
    logic [7:0] ch;
    logic       ok;
    logic [4:0] li;
    ch = 8'h00;
    ok = 1'b1;
    li = 5'd31;
    if (code[8]) begin
      ok = 1'b0;
    end else begin
      case (code[7:0])
        8'h1C: li = 5'd0;   8'h32: li = 5'd1;   8'h21: li = 5'd2;   8'h23: li = 5'd3;
        8'h24: li = 5'd4;   8'h2B: li = 5'd5;   8'h34: li = 5'd6;   8'h33: li = 5'd7;
        8'h43: li = 5'd8;   8'h3B: li = 5'd9;   8'h42: li = 5'd10;  8'h4B: li = 5'd11;
        8'h3A: li = 5'd12;  8'h31: li = 5'd13;  8'h44: li = 5'd14;  8'h4D: li = 5'd15;
        8'h15: li = 5'd16;  8'h2D: li = 5'd17;  8'h1B: li = 5'd18;  8'h2C: li = 5'd19;
        8'h3C: li = 5'd20;  8'h2A: li = 5'd21;  8'h1D: li = 5'd22;  8'h22: li = 5'd23;
        8'h35: li = 5'd24;  8'h1A: li = 5'd25;
        8'h45: ch = shift ? 8'h29 : 8'h30;
        8'h16: ch = shift ? 8'h21 : 8'h31;
        8'h1E: ch = shift ? 8'h40 : 8'h32;
        8'h26: ch = shift ? 8'h23 : 8'h33;
        8'h25: ch = shift ? 8'h24 : 8'h34;
        8'h2E: ch = shift ? 8'h25 : 8'h35;
        8'h36: ch = shift ? 8'h5E : 8'h36;
        8'h3D: ch = shift ? 8'h26 : 8'h37;
        8'h3E: ch = shift ? 8'h2A : 8'h38;
        8'h46: ch = shift ? 8'h28 : 8'h39;
        8'h70: ch = 8'h30;  8'h69: ch = 8'h31;  8'h72: ch = 8'h32;  8'h7A: ch = 8'h33;
        8'h6B: ch = 8'h34;  8'h73: ch = 8'h35;  8'h74: ch = 8'h36;  8'h6C: ch = 8'h37;
        8'h75: ch = 8'h38;  8'h7D: ch = 8'h39;
        8'h4E: ch = shift ? 8'h5F : 8'h2D;
        8'h55: ch = shift ? 8'h2B : 8'h3D;
        8'h29: ch = 8'h20;
        8'h5A: ch = 8'h0D;
        8'h66: ch = 8'h08;
        default: ok = 1'b0;
      endcase
    end
    if (li != 5'd31) ch = ((shift ^ caps) ? 8'h41 : 8'h61) + 8'(li);
    return {ok, ch};
  endfunction

  logic [8:0]    key_x_c;
  logic          key_char_ok;
  logic          caps_ev;
  logic [8:0]    rpt_x_c;
  logic          rpt_char_ok;
  logic          cand_ok;
  logic [7:0]    cand_ch;
  logic          pop_c;
  logic          push_c;
  logic          drop_c;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign key_x_c     = xlate(key_code, shift_down, caps_lock);
  assign key_char_ok = key_valid && key_make && key_x_c[8];
  assign caps_ev     = key_valid && key_make && (key_code == 9'h058);

`ifdef KBD_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_e;

  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  rpt_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [8:0]    held_q, held_d;
  logic          tick_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      held_q  <= 9'h000;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      held_q  <= held_d;
    end
  end

  // Timer runs in DELAY/REPEAT; a new eligible make restarts it, a break of the held key stops it.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    held_d  = held_q;
    tick_c  = 1'b0;
    case (state_q)
      IDLE: ;
      DELAY: begin
        if (timer_q == TW'(REPEAT_DELAY - 1)) begin
          tick_c  = 1'b1;
          state_d = REPEAT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      REPEAT: begin
        if (timer_q == TW'(REPEAT_RATE - 1)) begin
          tick_c  = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (key_char_ok) begin
      state_d = DELAY;
      held_d  = key_code;
      timer_d = '0;
    end else if (key_valid && !key_make && (key_code == held_q) && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  assign rpt_x_c     = xlate(held_q, shift_down, caps_lock);
  assign rpt_char_ok = tick_c && !key_valid && rpt_x_c[8];
`else
  logic unused_repeat;
  assign unused_repeat = ^{REPEAT_DELAY, REPEAT_RATE};
  assign rpt_x_c       = 9'h000;
  assign rpt_char_ok   = 1'b0;
`endif

  assign cand_ok   = key_char_ok || rpt_char_ok;
  assign cand_ch   = key_char_ok ? key_x_c[7:0] : rpt_x_c[7:0];
  assign out_valid = (count != '0);
  assign out_ascii = out_valid ? mem[rd_ptr] : 8'h00;
  assign pop_c     = out_valid && out_ready;
  assign push_c    = cand_ok && ((count < CW'(DEPTH)) || pop_c);
  assign drop_c    = cand_ok && !push_c;

  // FIFO storage, occupancy, sticky overflow, Caps Lock and last-character history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem        <= '{default: 8'h00};
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      caps_lock  <= 1'b0;
      last_ascii <= 8'h00;
      prev_ascii <= 8'h00;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= cand_ch;
        wr_ptr      <= wr_ptr + PW'(1);
        last_ascii  <= cand_ch;
        prev_ascii  <= last_ascii;
      end
      if (pop_c) rd_ptr <= rd_ptr + PW'(1);
      if (push_c && !pop_c)      count <= count + CW'(1);
      else if (pop_c && !push_c) count <= count - CW'(1);
      if (drop_c)       overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (caps_ev) caps_lock <= ~caps_lock;
    end
  end

endmodule

// File: tb/tb_kbd_ascii_queue.sv
// Scoreboard bench for kbd_ascii_queue; honours KBD_AUTOREPEAT_EN for the repeat scenarios.
module tb_kbd_ascii_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef KBD_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          key_valid = 1'b0;
  logic [8:0]    key_code = 9'h000;
  logic          key_make = 1'b0;
  logic          shift_down = 1'b0;
  logic          out_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          out_valid;
  logic [7:0]    out_ascii;
  logic [CW-1:0] count;
  logic          overflow;
  logic          caps_lock;
  logic [7:0]    last_ascii;
  logic [7:0]    prev_ascii;

  kbd_ascii_queue #(.DEPTH(DEPTH), .REPEAT_DELAY(20), .REPEAT_RATE(5)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .key_make(key_make),
    .shift_down(shift_down), .out_ready(out_ready), .ovf_clr(ovf_clr),
    .out_valid(out_valid), .out_ascii(out_ascii), .count(count), .overflow(overflow),
    .caps_lock(caps_lock), .last_ascii(last_ascii), .prev_ascii(prev_ascii)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  byte unsigned exp_q [$];
  bit caps_m = 1'b0;
  byte unsigned last_m = 8'h00;
  byte unsigned prev_m = 8'h00;

  byte unsigned let_c [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  byte unsigned dig_c  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  byte unsigned dig_sh [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28};
  byte unsigned kp_c   [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

  // Reference keymap built from lookup tables.
  function automatic bit m_xlate(input logic [8:0] code, input bit sh, input bit cp,
                                 output byte unsigned ch);
    ch = 8'h00;
    if (code[8]) return 1'b0;
    for (int i = 0; i < 26; i++)
      if (code[7:0] == let_c[i]) begin
        ch = 8'(((sh ^ cp) ? 65 : 97) + i);
        return 1'b1;
      end
    for (int i = 0; i < 10; i++) begin
      if (code[7:0] == dig_c[i]) begin
        ch = sh ? dig_sh[i] : 8'(48 + i);
        return 1'b1;
      end
      if (code[7:0] == kp_c[i]) begin
        ch = 8'(48 + i);
        return 1'b1;
      end
    end
    case (code[7:0])
      8'h4E: ch = sh ? 8'h5F : 8'h2D;
      8'h55: ch = sh ? 8'h2B : 8'h3D;
      8'h29: ch = 8'h20;
      8'h5A: ch = 8'h0D;
      8'h66: ch = 8'h08;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Consumer side: every accepted character is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got 0x%02h, required no character", out_ascii);
      end else begin
        byte unsigned e;
        e = exp_q.pop_front();
        if (out_ascii !== e) begin
          n_fail++;
          $display("FAIL sb_char: got 0x%02h, required 0x%02h", out_ascii, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic key(input logic [8:0] code, input logic make);
    key_valid = 1'b1;
    key_code  = code;
    key_make  = make;
    tick(1);
    key_valid = 1'b0;
  endtask

  task automatic press_expect(input logic [8:0] code, input bit sh);
    byte unsigned ch;
    shift_down = sh;
    if (code == 9'h058) caps_m = ~caps_m;
    else if (m_xlate(code, sh, caps_m, ch)) begin
      exp_q.push_back(ch);
      prev_m = last_m;
      last_m = ch;
    end
    key(code, 1'b1);
    key(code, 1'b0);
  endtask

  task automatic test_reset;
    tick(2);
    n_checks++;
    if ({out_valid, out_ascii, count, overflow, caps_lock, last_ascii, prev_ascii} !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h, required 0", {out_valid, out_ascii, count, overflow,
               caps_lock, last_ascii, prev_ascii});
    end
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_basic;
    out_ready  = 1'b1;
    shift_down = 1'b0;
    exp_q.push_back(8'h61);
    prev_m = last_m;
    last_m = 8'h61;
    key(9'h01C, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_latency: out_valid %0b, required 1", out_valid);
    end
    n_checks++;
    if ({last_ascii, prev_ascii} !== 16'h6100) begin
      n_fail++;
      $display("FAIL basic_history: got %h, required 6100", {last_ascii, prev_ascii});
    end
    key(9'h01C, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_one_cycle: out_valid %0b, required 0", out_valid);
    end
  endtask

  task automatic test_caps_and_map;
    logic [9:0] tbl [14] = '{{1'b1, 9'h01C}, {1'b1, 9'h045}, {1'b1, 9'h070}, {1'b1, 9'h04E},
                             {1'b0, 9'h055}, {1'b1, 9'h055}, {1'b1, 9'h029}, {1'b1, 9'h05A},
                             {1'b0, 9'h066}, {1'b1, 9'h11C}, {1'b0, 9'h00E}, {1'b0, 9'h01C},
                             {1'b0, 9'h016}, {1'b1, 9'h016}};
    press_expect(9'h058, 1'b0);
    n_checks++;
    if (caps_lock !== 1'b1) begin
      n_fail++;
      $display("FAIL caps_on: got %0b, required 1", caps_lock);
    end
    for (int i = 0; i < 14; i++) press_expect(tbl[i][8:0], tbl[i][9]);
    tick(2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL map_drained: %0d characters missing", exp_q.size());
    end
    n_checks++;
    if ({last_ascii, prev_ascii} !== {last_m, prev_m}) begin
      n_fail++;
      $display("FAIL map_history: got %h, required %h", {last_ascii, prev_ascii}, {last_m, prev_m});
    end
    press_expect(9'h058, 1'b0);
    n_checks++;
    if (caps_lock !== 1'b0) begin
      n_fail++;
      $display("FAIL caps_off: got %0b, required 0", caps_lock);
    end
  endtask

  task automatic test_overflow_full;
    int budget;
    out_ready  = 1'b0;
    shift_down = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        exp_q.push_back(8'h31);
        prev_m = last_m;
        last_m = 8'h31;
      end
      key(9'h016, 1'b1);
      key(9'h016, 1'b0);
    end
    n_checks++;
    if ({count, overflow} !== {CW'(8), 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_full: count %0d overflow %0b, required 8 1", count, overflow);
    end
    n_checks++;
    if ({last_ascii, prev_ascii} !== 16'h3131) begin
      n_fail++;
      $display("FAIL ovf_history: got %h, required 3131", {last_ascii, prev_ascii});
    end
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr: got %0b, required 0", overflow);
    end
    exp_q.push_back(8'h32);
    prev_m = last_m;
    last_m = 8'h32;
    out_ready = 1'b1;
    key(9'h01E, 1'b1);
    out_ready = 1'b0;
    n_checks++;
    if ({count, overflow} !== {CW'(8), 1'b0}) begin
      n_fail++;
      $display("FAIL full_pushpop: count %0d overflow %0b, required 8 0", count, overflow);
    end
    n_checks++;
    if ({last_ascii, prev_ascii} !== 16'h3231) begin
      n_fail++;
      $display("FAIL full_history: got %h, required 3231", {last_ascii, prev_ascii});
    end
    key(9'h01E, 1'b0);
    out_ready = 1'b1;
    budget = 0;
    while (count != '0 && budget < 20) begin
      tick(1);
      budget++;
    end
    n_checks++;
    if (count !== '0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: count %0d, %0d characters missing, required 0 0", count, exp_q.size());
    end
  endtask

  task automatic test_hold;
    byte unsigned w;
    bit rep;
    int extra;
    void'(m_xlate(9'h01D, 1'b0, 1'b0, w));
    out_ready  = 1'b1;
    shift_down = 1'b0;
    exp_q.push_back(w);
    key_valid = 1'b1;
    key_code  = 9'h01D;
    key_make  = 1'b1;
    tick(1);
    key_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_first: out_valid %0b, required 1", out_valid);
    end
    for (int j = 1; j < 40; j++) begin
      tick(1);
      if (j == 23) key_valid = 1'b0;
      rep = AR && (j == 20 || j == 25 || j == 30 || j == 35);
      if (rep) exp_q.push_back(w);
      n_checks++;
      if (out_valid !== rep) begin
        n_fail++;
        $display("FAIL hold_cycle_%0d: out_valid %0b, required %0b", j, out_valid, rep);
      end
      if (j == 22 || j == 39) begin
        key_valid = 1'b1;
        key_code  = (j == 22) ? 9'h01C : 9'h01D;
        key_make  = 1'b0;
      end
    end
    tick(1);
    key_valid = 1'b0;
    extra = 0;
    for (int j = 0; j < 20; j++) begin
      if (out_valid) extra++;
      tick(1);
    end
    n_checks++;
    if (extra != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL hold_stop: %0d extra cycles valid, %0d missing, required 0 0", extra, exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    out_ready  = 1'b0;
    shift_down = 1'b0;
    press_expect(9'h016, 1'b0);
    press_expect(9'h01E, 1'b0);
    exp_q.push_back(8'h77);
    key(9'h01D, 1'b1);
    tick(10);
    n_checks++;
    if (count !== CW'(3)) begin
      n_fail++;
      $display("FAIL mid_count: got %0d, required 3", count);
    end
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    last_m = 8'h00;
    prev_m = 8'h00;
    caps_m = 1'b0;
    n_checks++;
    if ({out_valid, out_ascii, count, overflow, caps_lock, last_ascii, prev_ascii} !== 31'd0) begin
      n_fail++;
      $display("FAIL mid_reset_state: got %h, required 0", {out_valid, out_ascii, count, overflow,
               caps_lock, last_ascii, prev_ascii});
    end
    rst = 1'b1;
    tick(1);
    out_ready = 1'b1;
    seen = 0;
    for (int j = 0; j < 40; j++) begin
      if (out_valid || count != '0) seen++;
      tick(1);
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL mid_no_push: %0d cycles with data, required 0", seen);
    end
    key(9'h01D, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_caps_and_map();
    test_overflow_full();
    test_hold();
    test_reset_mid();
    tick(2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_scoreboard: %0d characters outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
